// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module   : multicycle_control_pkg
// Brief    : Shared state, opcode-class and ALU-control definitions.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
    S_MEM_RD, S_WB_LD, S_MEM_WR, S_BR_CBZ, S_BR_UNC
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_ILLEGAL
  } opclass_t;

  localparam logic [10:0] C_OP_ADD  = 11'b10001011000;
  localparam logic [10:0] C_OP_SUB  = 11'b11001011000;
  localparam logic [10:0] C_OP_AND  = 11'b10001010000;
  localparam logic [10:0] C_OP_ORR  = 11'b10101010000;
  localparam logic [10:0] C_OP_LDUR = 11'b11111000010;
  localparam logic [10:0] C_OP_STUR = 11'b11111000000;
  // CBZ and B carry register/offset bits in their low opcode positions
  localparam logic [7:0]  C_OP_CBZ_HI = 8'b10110100;
  localparam logic [5:0]  C_OP_B_HI   = 6'b000101;

  localparam logic [3:0] C_ALU_AND   = 4'b0000;
  localparam logic [3:0] C_ALU_OR    = 4'b0001;
  localparam logic [3:0] C_ALU_ADD   = 4'b0010;
  localparam logic [3:0] C_ALU_SUB   = 4'b0110;
  localparam logic [3:0] C_ALU_PASSB = 4'b0111;

  localparam logic [1:0] C_SRCB_REG  = 2'b00;
  localparam logic [1:0] C_SRCB_IMM  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  localparam logic [1:0] C_PC_ALU    = 2'b00;
  localparam logic [1:0] C_PC_BRANCH = 2'b01;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_opcode_class_decode.sv
// ============================================================================
// Module   : opcode_class_decode
// Brief    : Combinational opcode classifier with R-type ALU control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module opcode_class_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] i_opcode,
  output opclass_t    o_class,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_reg2loc,
  output logic        o_illegal
);

  always_comb begin
    o_class    = CLS_ILLEGAL;
    o_alu_ctrl = C_ALU_ADD;
    if (i_opcode == C_OP_ADD) begin
      o_class    = CLS_RTYPE;
      o_alu_ctrl = C_ALU_ADD;
    end else if (i_opcode == C_OP_SUB) begin
      o_class    = CLS_RTYPE;
      o_alu_ctrl = C_ALU_SUB;
    end else if (i_opcode == C_OP_AND) begin
      o_class    = CLS_RTYPE;
      o_alu_ctrl = C_ALU_AND;
    end else if (i_opcode == C_OP_ORR) begin
      o_class    = CLS_RTYPE;
      o_alu_ctrl = C_ALU_OR;
    end else if (i_opcode == C_OP_LDUR) begin
      o_class    = CLS_LDUR;
    end else if (i_opcode == C_OP_STUR) begin
      o_class    = CLS_STUR;
    end else if (i_opcode[10:3] == C_OP_CBZ_HI) begin
      o_class    = CLS_CBZ;
      o_alu_ctrl = C_ALU_PASSB;
    end else if (i_opcode[10:5] == C_OP_B_HI) begin
      o_class    = CLS_B;
    end
  end

  // STUR and CBZ read their second operand from the Rt field
  assign o_reg2loc = (o_class == CLS_STUR) || (o_class == CLS_CBZ);
  assign o_illegal = (o_class == CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Multicycle datapath control FSM for a small ARM-like subset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [3:0]  ALUCtrl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        Reg2Loc,
  output logic        InstrDone,
  output logic        IllegalOp
);

  state_t     r_state;
  opclass_t   w_class;
  logic [3:0] w_rtype_alu;
  logic       w_reg2loc;
  logic       w_illegal;

  opcode_class_decode u_decode (
    .i_opcode   (Opcode),
    .o_class    (w_class),
    .o_alu_ctrl (w_rtype_alu),
    .o_reg2loc  (w_reg2loc),
    .o_illegal  (w_illegal)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_class)
            CLS_RTYPE:           r_state <= S_EXEC_R;
            CLS_LDUR, CLS_STUR:  r_state <= S_ADDR;
            CLS_CBZ:             r_state <= S_BR_CBZ;
            CLS_B:               r_state <= S_BR_UNC;
            default:             r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_ADDR: begin
          if (w_class == CLS_LDUR)      r_state <= S_MEM_RD;
          else if (w_class == CLS_STUR) r_state <= S_MEM_WR;
          else                          r_state <= S_FETCH;
        end
        S_MEM_RD: if (MemReady) r_state <= S_WB_LD;
        S_MEM_WR: if (MemReady) r_state <= S_FETCH;
        S_WB_R, S_WB_LD, S_BR_CBZ, S_BR_UNC: r_state <= S_FETCH;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend on the live MemReady/Zero, so they are decoded from state
  always_comb begin
    ALUCtrl   = C_ALU_AND;
    ALUSrcA   = 1'b0;
    ALUSrcB   = C_SRCB_REG;
    PCSrc     = C_PC_ALU;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    InstrDone = 1'b0;
    IllegalOp = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = C_SRCB_FOUR;
        ALUCtrl = C_ALU_ADD;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: IllegalOp = w_illegal;
      S_EXEC_R, S_WB_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = C_SRCB_REG;
        ALUCtrl = w_rtype_alu;
        if (r_state == S_WB_R) begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
      end
      S_ADDR, S_MEM_RD, S_MEM_WR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = C_SRCB_IMM;
        ALUCtrl = C_ALU_ADD;
        if (r_state == S_MEM_RD) MemRead = 1'b1;
        if (r_state == S_MEM_WR) begin
          MemWrite  = 1'b1;
          InstrDone = MemReady;
        end
      end
      S_WB_LD: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BR_CBZ: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = C_SRCB_REG;
        ALUCtrl   = C_ALU_PASSB;
        PCSrc     = C_PC_BRANCH;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      S_BR_UNC: begin
        PCSrc     = C_PC_BRANCH;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign Reg2Loc = w_reg2loc &&
                   ((r_state == S_DECODE) || (r_state == S_ADDR) ||
                    (r_state == S_MEM_WR) || (r_state == S_BR_CBZ));

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Randomized self-checking bench with an instruction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  logic        CLK;
  logic        resetl;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic [3:0]  ALUCtrl;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSrc;
  logic        PCWrite, IRWrite, MemRead, MemWrite, MemToReg;
  logic        RegWrite, Reg2Loc, InstrDone, IllegalOp;

  multicycle_control dut (
    .CLK(CLK), .resetl(resetl), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUCtrl(ALUCtrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .Reg2Loc(Reg2Loc),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw, irw, mrd, mwr, m2r, rw, r2l, done, ill;
  } outv_t;

  typedef struct {
    logic        mr;
    logic        zr;
    logic [10:0] op;
    outv_t       exp;
  } cyc_t;

  outv_t obs;
  assign obs = {ALUCtrl, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite, MemRead,
                MemWrite, MemToReg, RegWrite, Reg2Loc, InstrDone, IllegalOp};

  int   checks   = 0;
  int   failures = 0;
  cyc_t q[$];

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110011;

  // 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal
  function automatic int classify(input logic [10:0] op);
    casez (op)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return 0;
      11'b11111000010:                  return 1;
      11'b11111000000:                  return 2;
      11'b10110100???:                  return 3;
      11'b000101?????:                  return 4;
      default:                          return 5;
    endcase
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [10:0] op);
    case (op)
      OP_ADD:  return 4'b0010;
      OP_SUB:  return 4'b0110;
      OP_AND:  return 4'b0000;
      OP_ORR:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic void addc(input logic mr, input logic zr, input logic [10:0] op,
                               input outv_t e);
    cyc_t c;
    c.mr = mr; c.zr = zr; c.op = op; c.exp = e;
    q.push_back(c);
  endfunction

  // Builds the per-cycle expected trace of one instruction starting in FETCH.
  // fw/mw: fetch and memory wait cycles; zf: Zero in the branch cycle (<0 random)
  task automatic model_instr(input logic [10:0] op, input int fw, input int mw,
                             input int zf);
    int    cls;
    logic  r2l;
    logic  z;
    outv_t e;
    cls = classify(op);
    r2l = (cls == 2) || (cls == 3);
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mrd = 1'b1; e.srcb = 2'b10; e.alu = 4'b0010;
      e.irw = (i == fw); e.pcw = (i == fw);
      addc(i == fw, 1'($urandom), 11'($urandom), e);
    end
    e = '0; e.r2l = r2l; e.ill = (cls == 5);
    addc(1'($urandom), 1'($urandom), op, e);
    case (cls)
      0: begin
        e = '0; e.srca = 1'b1; e.srcb = 2'b00; e.alu = rtype_alu(op);
        addc(1'($urandom), 1'($urandom), op, e);
        e.rw = 1'b1; e.done = 1'b1;
        addc(1'($urandom), 1'($urandom), op, e);
      end
      1, 2: begin
        e = '0; e.srca = 1'b1; e.srcb = 2'b01; e.alu = 4'b0010; e.r2l = r2l;
        addc(1'($urandom), 1'($urandom), op, e);
        for (int i = 0; i <= mw; i++) begin
          if (cls == 1) e.mrd = 1'b1;
          else begin e.mwr = 1'b1; e.done = (i == mw); end
          addc(i == mw, 1'($urandom), op, e);
        end
        if (cls == 1) begin
          e = '0; e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
          addc(1'($urandom), 1'($urandom), op, e);
        end
      end
      3: begin
        z = (zf < 0) ? 1'($urandom) : (zf != 0);
        e = '0; e.srca = 1'b1; e.srcb = 2'b00; e.alu = 4'b0111; e.pcsrc = 2'b01;
        e.pcw = z; e.done = 1'b1; e.r2l = 1'b1;
        addc(1'($urandom), z, op, e);
      end
      4: begin
        e = '0; e.pcsrc = 2'b01; e.pcw = 1'b1; e.done = 1'b1;
        addc(1'($urandom), 1'($urandom), op, e);
      end
      default: ;
    endcase
  endtask

  // Drive one cycle from posedge+1, sample at the falling edge
  task automatic step(input cyc_t c, output outv_t o);
    Opcode = c.op; Zero = c.zr; MemReady = c.mr;
    @(negedge CLK);
    o = obs;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    outv_t o;
    cyc_t  c;
    Opcode = OP_ADD; MemReady = 1'b1; Zero = 1'b1;
    resetl = 1'b1;
    #1 resetl = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("FAIL reset_hold: got %h want %h", obs, 18'h0);
      end
    end
    @(posedge CLK); #1;
    resetl = 1'b1;
    c.mr = 1'b1; c.zr = 1'b1; c.op = OP_ADD; c.exp = '0;
    step(c, o);
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_idle: got %h want %h", o, 18'h0);
    end
  endtask

  task automatic test_add;
    outv_t o;
    model_instr(OP_ADD, 0, 0, -1);
    foreach (q[i]) begin
      step(q[i], o);
      checks++;
      if (o !== q[i].exp) begin
        failures++;
        $display("FAIL add cyc%0d: got %h want %h", i, o, q[i].exp);
      end
    end
  endtask

  task automatic test_ldur_wait;
    outv_t o;
    int    rd_cycles;
    rd_cycles = 0;
    model_instr(OP_LDUR, 1, 3, -1);
    foreach (q[i]) begin
      step(q[i], o);
      if (i > 2 && o.mrd) rd_cycles++;
      checks++;
      if (o !== q[i].exp) begin
        failures++;
        $display("FAIL ldur cyc%0d: got %h want %h", i, o, q[i].exp);
      end
    end
    checks++;
    if (rd_cycles !== 4) begin
      failures++;
      $display("FAIL ldur_memread_len: got %0d want %0d", rd_cycles, 4);
    end
  endtask

  task automatic test_stur;
    outv_t o;
    model_instr(OP_STUR, 0, 2, -1);
    foreach (q[i]) begin
      step(q[i], o);
      checks++;
      if (o !== q[i].exp) begin
        failures++;
        $display("FAIL stur cyc%0d: got %h want %h", i, o, q[i].exp);
      end
    end
  endtask

  task automatic test_cbz;
    outv_t o;
    for (int z = 1; z >= 0; z--) begin
      model_instr(OP_CBZ, 0, 0, z);
      foreach (q[i]) begin
        step(q[i], o);
        checks++;
        if (o !== q[i].exp) begin
          failures++;
          $display("FAIL cbz_z%0d cyc%0d: got %h want %h", z, i, o, q[i].exp);
        end
      end
    end
  endtask

  task automatic test_illegal;
    outv_t o;
    model_instr(11'b00000000000, 0, 0, -1);
    foreach (q[i]) begin
      step(q[i], o);
      checks++;
      if (o !== q[i].exp) begin
        failures++;
        $display("FAIL illegal cyc%0d: got %h want %h", i, o, q[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_memwr;
    outv_t o;
    cyc_t  c;
    outv_t e_wr;
    model_instr(OP_STUR, 0, 5, -1);
    e_wr = q[3].exp;
    for (int i = 0; i < 4; i++) begin
      step(q[i], o);
      checks++;
      if (o !== q[i].exp) begin
        failures++;
        $display("FAIL rst_memwr_pre cyc%0d: got %h want %h", i, o, q[i].exp);
      end
    end
    MemReady = 1'b0;
    #1;
    checks++;
    if (obs !== e_wr) begin
      failures++;
      $display("FAIL rst_memwr_wait: got %h want %h", obs, e_wr);
    end
    resetl = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL rst_memwr_async: got %h want %h", obs, 18'h0);
    end
    MemReady = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL rst_memwr_held: got %h want %h", obs, 18'h0);
    end
    resetl = 1'b1;
    c.mr = 1'b1; c.zr = 1'b0; c.op = OP_STUR; c.exp = '0;
    step(c, o);
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL rst_memwr_idle: got %h want %h", o, 18'h0);
    end
    model_instr(OP_ORR, 0, 0, -1);
    foreach (q[i]) begin
      step(q[i], o);
      checks++;
      if (o !== q[i].exp) begin
        failures++;
        $display("FAIL rst_memwr_after cyc%0d: got %h want %h", i, o, q[i].exp);
      end
    end
  endtask

  task automatic test_random;
    outv_t       o;
    logic [10:0] op;
    logic [10:0] ops [8];
    int          sel;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B};
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) op = ops[sel];
      else         op = 11'($urandom);
      if (sel == 6) op[2:0] = 3'($urandom);
      if (sel == 7) op[4:0] = 5'($urandom);
      model_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
      foreach (q[i]) begin
        step(q[i], o);
        checks++;
        if (o !== q[i].exp) begin
          failures++;
          $display("FAIL rand n%0d op%b cyc%0d: got %h want %h", n, op, i, o, q[i].exp);
        end
      end
    end
  endtask

  initial begin
    resetl   = 1'b1;
    Opcode   = '0;
    Zero     = 1'b0;
    MemReady = 1'b0;
    test_reset;
    test_add;
    test_ldur_wait;
    test_stur;
    test_cbz;
    test_illegal;
    test_reset_mid_memwr;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
